// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and fetch types
// Purpose: next-PC operation codes (also used by the control decoder),
//          the fetch FSM state type and the fetch queue entry layout.
// Ports:   none (package).
package cpu_pkg;

  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_WAIT = 2'd1,
    FS_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Only these codes change control flow; every other code behaves as PLUS4.
  function automatic logic is_redirect(input logic [2:0] op);
    return (op == NPC_BRANCH) || (op == NPC_JUMP) || (op == NPC_JALR);
  endfunction

endpackage

// File: rtl/ifetch_q.sv
// rtl/ifetch_q.sv - two-entry instruction queue of {pc, inst}
// Purpose: holds fetched instructions between the memory port and decode.
// Ports:   clk, rst      clock, synchronous active-high reset
//          push_i/din_i  write an entry
//          pop_i         consume the head entry
//          flush_i       discard everything (wins over push/pop)
//          head_o        head entry, held stable until popped
//          count_o       occupancy 0..2
module ifetch_q
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t din_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  fetch_entry_t slot0_q, slot0_d;
  fetch_entry_t slot1_q, slot1_d;
  logic [1:0]   count_q, count_d;
  logic         do_pop, do_push;

  assign do_pop  = pop_i && (count_q != 2'd0);
  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  // slot0 is always the head, so the head never moves unless it is popped.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else if (do_pop) begin
      slot0_d = slot1_q;
      if (do_push) begin
        if (count_q == 2'd1) slot0_d = din_i;
        else                 slot1_d = din_i;
      end else begin
        count_d = count_q - 2'd1;
      end
    end else if (do_push) begin
      if (count_q == 2'd0) slot0_d = din_i;
      else                 slot1_d = din_i;
      count_d = count_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  assign head_o  = slot0_q;
  assign count_o = count_q;

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch unit with redirect handling
// Purpose: issues one outstanding instruction read at a time, queues results
//          for decode, and restarts from a new PC on a control-flow redirect.
// Ports:   clk, rst                         clock, synchronous active-high reset
//          imem_req/addr/gnt/rvalid/rdata   instruction memory port
//          inst_valid/ready, inst, inst_pc  decode-side queue head
//          redir_valid, npc_op, redir_pc,
//          imm, alu_out                     redirect request from execute
//          misalign                         pulse: redirect target had bit 1 set
module ifetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redir_valid,
  input  logic [2:0]  npc_op,
  input  logic [31:0] redir_pc,
  input  logic [31:0] imm,
  input  logic [31:0] alu_out,
  output logic        misalign
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         misalign_q, misalign_d;

  logic         eff_redir;
  logic [31:0]  target_raw;
  logic         q_push, q_pop, q_full;
  logic [1:0]   q_count;
  fetch_entry_t q_head;

  assign eff_redir = redir_valid && is_redirect(npc_op);

  always_comb begin
    target_raw = redir_pc + imm;
    if (npc_op == NPC_JALR) target_raw = alu_out & ~32'h1;
  end

  assign q_full = (q_count == QDEPTH[1:0]);
  // A redirect flushes the queue, so it suppresses both push and pop.
  assign q_push = (state_q == FS_WAIT) && imem_rvalid && !eff_redir;
  assign q_pop  = inst_valid && inst_ready && !eff_redir;

  ifetch_q u_q (
    .clk     (clk),
    .rst     (rst),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .flush_i (eff_redir),
    .din_i   ('{pc: fetch_pc_q, inst: imem_rdata}),
    .head_o  (q_head),
    .count_o (q_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FS_IDLE;
      fetch_pc_q <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    misalign_d = eff_redir && target_raw[1];
    case (state_q)
      FS_IDLE: if (imem_req && imem_gnt) state_d = FS_WAIT;
      // A read returning with a redirect in the same cycle is simply discarded.
      FS_WAIT: begin
        if (imem_rvalid)    state_d = FS_IDLE;
        else if (eff_redir) state_d = FS_DROP;
      end
      FS_DROP: if (imem_rvalid) state_d = FS_IDLE;
      default: state_d = FS_IDLE;
    endcase
    if (eff_redir)   fetch_pc_d = target_raw & 32'hFFFF_FFFC;
    else if (q_push) fetch_pc_d = fetch_pc_q + 32'd4;
  end

  // Outputs are gated by rst so nothing leaks out during the reset cycle itself.
  always_comb begin
    imem_req   = !rst && (state_q == FS_IDLE) && !q_full && !eff_redir;
    imem_addr  = fetch_pc_q;
    inst_valid = !rst && (q_count != 2'd0);
    inst       = q_head.inst;
    inst_pc    = q_head.pc;
    misalign   = !rst && misalign_q;
  end

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - scoreboard bench for ifetch
module tb_ifetch;

  localparam int NCYC = 3200;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redir_valid;
  logic [2:0]  npc_op;
  logic [31:0] redir_pc;
  logic [31:0] imm;
  logic [31:0] alu_out;
  logic        misalign;

  ifetch #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .redir_valid (redir_valid),
    .npc_op      (npc_op),
    .redir_pc    (redir_pc),
    .imm         (imm),
    .alu_out     (alu_out),
    .misalign    (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   mon_size = 0;
  int   n_consumed = 0;

  // Reference model: outstanding-read bookkeeping and next expected fetch address
  logic [31:0] m_pc = 32'h0;
  logic        m_out = 1'b0;
  logic        m_drop = 1'b0;
  logic [31:0] m_out_pc = 32'h0;
  logic        m_mis = 1'b0;

  // Memory responder state (stimulus side; survives reset to produce stale data)
  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_lat = 0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic eff_of(input logic v, input logic [2:0] op);
    return v && (op == 3'b001 || op == 3'b010 || op == 3'b100);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the queue head with the scoreboard and pops on consume.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        chk("inst_valid_rst", inst_valid, 0);
        mon_size = 0;
      end else begin
        mon_size = sb.size();
        chk("inst_valid", inst_valid, (sb.size() != 0));
        if (inst_valid && sb.size() > 0) begin
          chk("inst_pc", inst_pc, sb[0].pc);
          chk("inst", inst, sb[0].ins);
          if (inst_ready && !eff_of(redir_valid, npc_op)) begin
            void'(sb.pop_front());
            n_consumed++;
          end
        end
      end
    end
  end

  // Driver + model update
  logic [31:0] g_addr [3];
  int          g_n = 0;
  int          seen_full = 0;
  int          lat_sel = 0;
  logic        gnt_en;
  logic        done_br = 1'b0;
  logic        done_rst = 1'b0;
  logic        exp_req;
  logic        eff;
  logic [31:0] t;

  initial begin
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    inst_ready = 1'b0; redir_valid = 1'b0; npc_op = 3'b000;
    redir_pc = 32'h0; imm = 32'h0; alu_out = 32'h0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      rst = (cyc < 4);
      redir_valid = 1'b0;
      npc_op = 3'b000;
      redir_pc = $urandom;
      imm = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 64)) - 32'd32;
      alu_out = $urandom;
      if (cyc < 130) begin
        gnt_en = 1'b1;
        lat_sel = (cyc >= 60) ? 2 : 0;
        inst_ready = !(cyc >= 30 && cyc < 45);
        if (cyc >= 60 && !done_br && m_out && mem_busy && mem_lat >= 1) begin
          redir_valid = 1'b1; npc_op = 3'b001; redir_pc = 32'h10; imm = 32'hFFFF_FFF8;
          done_br = 1'b1;
        end
        if (cyc == 80) begin redir_valid = 1'b1; npc_op = 3'b100; alu_out = 32'h101; end
        if (cyc == 90) begin redir_valid = 1'b1; npc_op = 3'b100; alu_out = 32'h106; end
        if (cyc == 100) begin redir_valid = 1'b1; npc_op = 3'b011; redir_pc = 32'h400; imm = 32'h40; end
        if (cyc >= 110 && !done_rst && m_out && mem_busy && mem_lat == 1) begin
          rst = 1'b1;
          done_rst = 1'b1;
        end
      end else begin
        gnt_en = ($urandom_range(0, 9) < 7);
        lat_sel = $urandom_range(0, 3);
        inst_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 99) < 6) begin
          redir_valid = 1'b1;
          npc_op = 3'($urandom_range(0, 7));
        end
        if ($urandom_range(0, 999) < 4) rst = 1'b1;
      end
      imem_gnt = gnt_en && !mem_busy;
      imem_rvalid = mem_busy && (mem_lat == 0);
      imem_rdata = imem_rvalid ? mem_fn(mem_addr) : $urandom;
      #2;
      if (rst) begin
        chk("imem_req_rst", imem_req, 0);
        chk("misalign_rst", misalign, 0);
        m_pc = 32'h0; m_out = 1'b0; m_drop = 1'b0; m_mis = 1'b0;
        sb.delete();
      end else begin
        eff = eff_of(redir_valid, npc_op);
        exp_req = !m_out && (mon_size < 2) && !eff;
        chk("imem_req", imem_req, exp_req);
        if (exp_req) chk("imem_addr", imem_addr, m_pc);
        chk("misalign", misalign, m_mis);
        if (cyc >= 30 && cyc < 45 && mon_size == 2 && !imem_req) seen_full++;
        t = (npc_op == 3'b100) ? (alu_out & ~32'h1) : (redir_pc + imm);
        m_mis = eff && t[1];
        if (eff) begin
          sb.delete();
          m_pc = t & ~32'h3;
          if (m_out) begin
            if (imem_rvalid) m_out = 1'b0;
            else             m_drop = 1'b1;
          end
        end else if (m_out && imem_rvalid) begin
          m_out = 1'b0;
          if (!m_drop) begin
            sb.push_back('{pc: m_out_pc, ins: mem_fn(m_out_pc)});
            m_pc = m_out_pc + 32'd4;
          end
        end else if (exp_req && imem_gnt) begin
          m_out = 1'b1; m_drop = 1'b0; m_out_pc = m_pc;
        end
      end
      if (imem_rvalid) mem_busy = 1'b0;
      if (imem_req && imem_gnt) begin
        mem_busy = 1'b1; mem_addr = imem_addr; mem_lat = lat_sel;
        if (cyc < 30 && g_n < 3) begin g_addr[g_n] = imem_addr; g_n++; end
      end else if (mem_busy && !imem_rvalid) begin
        mem_lat--;
      end
    end
    chk("first_addr0", g_addr[0], 32'h0);
    chk("first_addr1", g_addr[1], 32'h4);
    chk("first_addr2", g_addr[2], 32'h8);
    chk("queue_filled_stall", (seen_full > 0), 1);
    chk("branch_fired", done_br, 1);
    chk("wait_reset_fired", done_rst, 1);
    chk("progress", (n_consumed >= 200), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
